// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_W      = 8;
    localparam int unsigned DEF_PROD_W = 2 * DEF_W;

    // Iteration counter width: clog2(w), never below one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : int'($clog2(w));
    endfunction

endpackage

// File: rtl/mult_addsub.sv
// Combinational N-bit ripple adder/subtractor: s = x + y, or x - y when sub is set.
module mult_addsub #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N-1:0] s
);

    // Subtraction as x + ~y + 1, the +1 entering as the chain's carry-in.
    always_comb begin
        logic carry;
        logic yb;
        carry = sub;
        yb    = 1'b0;
        s     = '0;
        for (int i = 0; i < int'(N); i++) begin
            yb    = y[i] ^ sub;
            s[i]  = x[i] ^ yb ^ carry;
            carry = (x[i] & yb) | (carry & (x[i] ^ yb));
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, one multiplier bit per clock, unsigned or
// two's-complement per operation, with a start/done handshake.
module seq_mult
    import mult_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   p
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = cnt_width(W);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    mq_q,    mq_d;
    logic [W:0]      acc_q,   acc_d;
    logic            sgn_q,   sgn_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [PW-1:0]   p_q,     p_d;

    logic [W:0]      mext;
    logic [W:0]      addend;
    logic [W:0]      sum;
    logic            last;
    logic            sub;
    logic            fill;
    logic            accept;

    // Multiplicand widened to the accumulator width; the final signed step subtracts.
    always_comb begin
        mext   = sgn_q ? {mcand_q[W-1], mcand_q} : {1'b0, mcand_q};
        addend = mq_q[0] ? mext : '0;
        last   = (cnt_q == CW'(W - 1));
        sub    = sgn_q & last;
        fill   = sgn_q & sum[W];
    end

    mult_addsub #(.N(W + 1)) u_addsub (
        .x   (acc_q),
        .y   (addend),
        .sub (sub),
        .s   (sum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mq_d    = mq_q;
        acc_d   = acc_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        p_d     = p_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                acc_d = {fill, sum[W:1]};
                mq_d  = {sum[0], mq_q[W-1:1]};
                if (last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                p_d     = {acc_q[W-1:0], mq_q};
                state_d = IDLE;
                accept  = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            mcand_d = a;
            mq_d    = b;
            acc_d   = '0;
            sgn_d   = signed_mode;
        end

        // busy drops on the done pulse, even when a back-to-back op is accepted there.
        busy_d = (state_d != IDLE) && !done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mq_q    <= '0;
            acc_q   <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mq_q    <= mq_d;
            acc_q   <= acc_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult at W=4, 8 and 16: cycle-level reference for W=8 plus
// directed and exhaustive product checks.
module tb_seq_mult;

    logic        clk;
    logic        rst;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        start4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int total = 0;
    int bad   = 0;

    seq_mult #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
    );

    seq_mult #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
    );

    seq_mult #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product of two w-bit operands, reduced to 2w bits.
    function automatic longint unsigned ref_prod(input int w, input bit s,
                                                 input longint unsigned av,
                                                 input longint unsigned bv);
        longint sa, sb;
        longint unsigned mask;
        mask = (64'd1 << (2 * w)) - 64'd1;
        sa = longint'(av);
        sb = longint'(bv);
        if (s) begin
            if (((av >> (w - 1)) & 64'd1) != 0) sa = sa - (64'sd1 <<< w);
            if (((bv >> (w - 1)) & 64'd1) != 0) sb = sb - (64'sd1 <<< w);
        end
        return longint'(sa * sb) & mask;
    endfunction

    // Reference behaviour for the W=8 instance: ops complete W+1 edges after acceptance.
    bit              m_active = 1'b0;
    int              m_age    = 0;
    bit              m_busy   = 1'b0;
    bit              m_done   = 1'b0;
    longint unsigned m_p      = 0;
    longint unsigned m_pend   = 0;

    always @(posedge clk) begin
        bit free;
        if (rst) begin
            m_active = 1'b0;
            m_age    = 0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_p      = 0;
        end else begin
            free   = !m_active || (m_age == 8);
            m_done = 1'b0;
            if (m_active) begin
                m_age++;
                if (m_age == 9) begin
                    m_done   = 1'b1;
                    m_p      = m_pend;
                    m_active = 1'b0;
                end
            end
            if (free && start8) begin
                m_active = 1'b1;
                m_age    = 0;
                m_pend   = ref_prod(8, sm8, 64'(a8), 64'(b8));
            end
            m_busy = m_active && !m_done;
        end
    end

    always @(negedge clk) begin
        check("w8_busy", 64'(busy8), 64'(m_busy));
        check("w8_done", 64'(done8), 64'(m_done));
        check("w8_p",    64'(p8),    m_p);
        check("w8_busy_done_excl", 64'(busy8 & done8), 64'd0);
    end

    task automatic drive(input int w, input bit st, input bit s,
                         input longint unsigned av, input longint unsigned bv);
        case (w)
            4:       begin start4  = st; sm4  = s; a4  = 4'(av);  b4  = 4'(bv);  end
            8:       begin start8  = st; sm8  = s; a8  = 8'(av);  b8  = 8'(bv);  end
            default: begin start16 = st; sm16 = s; a16 = 16'(av); b16 = 16'(bv); end
        endcase
    endtask

    function automatic logic get_busy(input int w);
        return (w == 4) ? busy4 : (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 4) ? done4 : (w == 8) ? done8 : done16;
    endfunction

    function automatic longint unsigned get_p(input int w);
        return (w == 4) ? 64'(p4) : (w == 8) ? 64'(p8) : 64'(p16);
    endfunction

    // Single start pulse; operands are scrambled right after acceptance.
    task automatic run_op(input int w, input bit s, input longint unsigned av,
                          input longint unsigned bv, input longint unsigned exp,
                          input string name);
        int lat;
        int bcnt;
        lat  = -1;
        bcnt = 0;
        @(negedge clk);
        drive(w, 1'b1, s, av, bv);
        for (int i = 1; i <= 3 * w + 10; i++) begin
            @(negedge clk);
            if (i == 1) drive(w, 1'b0, ~s, ~av, ~bv);
            if (get_busy(w)) bcnt++;
            if (get_done(w)) begin
                lat = i - 1;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(w + 1));
        check({name, "_p"}, get_p(w), exp);
        check({name, "_busy_cycles"}, 64'(bcnt), 64'(w + 1));
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        drive(4, 1'b0, 1'b0, 0, 0);
        drive(8, 1'b0, 1'b0, 0, 0);
        drive(16, 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_done8", 64'(done8), 64'd0);
        check("reset_p8",    64'(p8),    64'd0);
        check("reset_p4",    64'(p4),    64'd0);
        check("reset_busy16", 64'(busy16 | done16), 64'd0);
        check("reset_p16",   64'(p16),   64'd0);
        rst = 1'b0;

        run_op(8, 1'b0, 255, 255, 64'hFE01, "w8_u_255x255");
        run_op(8, 1'b1, 8'h80, 8'h80, 64'h4000, "w8_s_m128xm128");
        run_op(8, 1'b1, 8'hFF, 8'h7F, 64'hFF81, "w8_s_m1x127");
        run_op(8, 1'b0, 8'h80, 8'hFF, 64'h7F80, "w8_u_128x255");

        // start held high with operands changing every cycle.
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
        dones = 0;
        for (int j = 1; j <= 28; j++) begin
            @(negedge clk);
            if (done8) dones++;
            sm8 = 1'(j % 2);
            a8  = 8'(j * 37 + 11);
            b8  = 8'(j * 53 + 200);
        end
        check("w8_b2b_done_count", 64'(dones), 64'd3);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Reset during RUN discards the operation.
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd100;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("w8_abort_busy", 64'(busy8), 64'd0);
        check("w8_abort_done", 64'(done8), 64'd0);
        check("w8_abort_p",    64'(p8),    64'd0);
        rst = 1'b0;
        dones = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("w8_abort_no_done", 64'(dones), 64'd0);
        run_op(8, 1'b0, 3, 5, 64'd15, "w8_u_3x5");

        run_op(4, 1'b0, 15, 15, 64'hE1, "w4_u_15x15");
        run_op(4, 1'b1, 8, 8, 64'h40, "w4_s_m8xm8");
        run_op(4, 1'b1, 8, 7, 64'hC8, "w4_s_m8x7");
        for (int s = 0; s < 2; s++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    run_op(4, 1'(s), 64'(av), 64'(bv),
                           ref_prod(4, 1'(s), 64'(av), 64'(bv)), "w4_exh");
                end
            end
        end

        run_op(16, 1'b1, 16'h8000, 16'h7FFF, 64'hC0008000, "w16_s_min_x_max");
        run_op(16, 1'b0, 16'hFFFF, 16'hFFFF, 64'hFFFE0001, "w16_u_max_x_max");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
